// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: qualifies PLL lock, sequences PLL and system resets, reports lock loss and failure
module pll_lock_rst_gen #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       ext_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_stable,
  output logic       pll_fail,
  output logic [7:0] lock_loss_cnt
);
  localparam int M1   = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CMAX = M1 > LOCK_TIMEOUT_CYCLES ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STBL_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [1:0] {PLLRST, WAIT_LOCK, STABLE, RUN} state_t;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [RW-1:0]          r_retry;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  assign w_lock_s    = r_sync[SYNC_STAGES-1];
  assign pll_rst     = r_state == PLLRST;
  assign sys_rst     = r_state != RUN;
  assign lock_stable = r_state == RUN;
  // plain flop chain bringing the asynchronous lock into the clk domain
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], lock};
  // reset sequencer: PLL reset pulse, lock wait with timeout, stability qualification, run
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= PLLRST;
      r_cnt         <= '0;
      r_retry       <= '0;
      pll_fail      <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (ext_rst_req) begin
      r_state  <= PLLRST;
      r_cnt    <= '0;
      r_retry  <= '0;
      pll_fail <= 1'b0;
    end else
      case (r_state)
        PLLRST: begin
          r_state <= r_cnt == PRST_LAST ? WAIT_LOCK : PLLRST;
          r_cnt   <= r_cnt == PRST_LAST ? '0 : r_cnt + 1'b1;
        end
        WAIT_LOCK:
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TOUT_LAST) begin
            r_state  <= PLLRST;
            r_cnt    <= '0;
            r_retry  <= r_retry == RETRY_MAX ? r_retry : r_retry + 1'b1;
            pll_fail <= pll_fail | (r_retry >= RETRY_MAX - 1'b1);
          end else
            r_cnt <= r_cnt + 1'b1;
        STABLE:
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STBL_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_retry <= '0;
          end else
            r_cnt <= r_cnt + 1'b1;
        default:
          if (!w_lock_s) begin
            r_state       <= PLLRST;
            r_cnt         <= '0;
            lock_loss_cnt <= lock_loss_cnt + {7'd0, lock_loss_cnt != 8'hFF};
          end
      endcase
endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// tb_pll_lock_rst_gen: scoreboard bench comparing the reset sequencer against a phase/time reference model
module tb_pll_lock_rst_gen;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int L  = 8;
  localparam int T  = 32;
  localparam int MR = 3;
  logic       clk = 0, rst = 1, lock = 0, ext_rst_req = 0;
  logic       pll_rst, sys_rst, lock_stable, pll_fail;
  logic [7:0] lock_loss_cnt;
  int vectors = 0, miscompares = 0;
  logic [11:0] sb[$];
  pll_lock_rst_gen #(.SYNC_STAGES(S), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(L),
                     .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .lock(lock), .ext_rst_req(ext_rst_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_stable(lock_stable),
    .pll_fail(pll_fail), .lock_loss_cnt(lock_loss_cnt));
  always #5 clk = ~clk;
  string ph;
  int    t, retries, losses;
  bit    fail, ls;
  bit    hist[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = "PLLRST"; t = 0; retries = 0; fail = 0; losses = 0;
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
      sb.delete();
    end else begin
      ls = hist.pop_front();
      hist.push_back(lock);
      if (ext_rst_req) begin
        ph = "PLLRST"; t = 0; retries = 0; fail = 0;
      end else if (ph == "PLLRST") begin
        t++;
        if (t == P) begin ph = "WAIT"; t = 0; end
      end else if (ph == "WAIT") begin
        if (ls) begin ph = "STABLE"; t = 0; end
        else begin
          t++;
          if (t == T) begin
            ph = "PLLRST"; t = 0;
            retries = retries < MR ? retries + 1 : MR;
            if (retries == MR) fail = 1;
          end
        end
      end else if (ph == "STABLE") begin
        if (!ls) begin ph = "WAIT"; t = 0; end
        else begin
          t++;
          if (t == L) begin ph = "RUN"; t = 0; retries = 0; end
        end
      end else if (!ls) begin
        ph = "PLLRST"; t = 0;
        losses = losses < 255 ? losses + 1 : 255;
      end
    end
    sb.push_back({ph == "PLLRST", ph != "RUN", ph == "RUN", fail, 8'(losses)});
  end
  always @(negedge clk)
    if (sb.size() > 0) begin
      logic [11:0] e, a;
      e = sb.pop_front();
      a = {pll_rst, sys_rst, lock_stable, pll_fail, lock_loss_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t {pll_rst,sys_rst,lock_stable,pll_fail,loss}: got %b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                 $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    #23 rst = 0;
    #1;
    chk("reset_pll_rst", 8'(pll_rst), 8'd1);
    chk("reset_sys_rst", 8'(sys_rst), 8'd1);
    chk("reset_lock_stable", 8'(lock_stable), 8'd0);
    chk("reset_loss_cnt", lock_loss_cnt, 8'd0);
    tick(3);
    chk("pll_rst_after_3", 8'(pll_rst), 8'd1);
    tick(1);
    chk("pll_rst_after_4", 8'(pll_rst), 8'd0);
    tick(6);
    lock = 1;
    tick(10);
    chk("sys_rst_lock_plus_9", 8'(sys_rst), 8'd1);
    tick(1);
    chk("sys_rst_lock_plus_10", 8'(sys_rst), 8'd0);
    chk("lock_stable_run", 8'(lock_stable), 8'd1);
    ext_rst_req = 1; lock = 0;
    tick(1);
    ext_rst_req = 0;
    tick(10);
    lock = 1; tick(5);
    lock = 0; tick(1);
    lock = 1; tick(20);
    chk("run_after_dropout", 8'(lock_stable), 8'd1);
    lock = 0;
    tick(2);
    ext_rst_req = 1;
    tick(1);
    ext_rst_req = 0;
    chk("ext_drop_pll_rst", 8'(pll_rst), 8'd1);
    chk("ext_drop_loss_held", lock_loss_cnt, 8'd0);
    lock = 1;
    tick(20);
    for (int i = 0; i < 300; i++) begin
      lock = 0; tick(1);
      lock = 1; tick(20);
    end
    chk("loss_saturated", lock_loss_cnt, 8'd255);
    lock = 0;
    tick(150);
    chk("pll_fail_set", 8'(pll_fail), 8'd1);
    lock = 1;
    tick(30);
    chk("run_with_fail", 8'({lock_stable, pll_fail}), 8'd3);
    ext_rst_req = 1;
    tick(1);
    ext_rst_req = 0;
    chk("fail_cleared", 8'(pll_fail), 8'd0);
    lock = 0;
    tick(8);
    lock = 1;
    tick(4);
    #2 rst = 1;
    #1;
    chk("async_pll_rst", 8'(pll_rst), 8'd1);
    chk("async_sys_rst", 8'(sys_rst), 8'd1);
    chk("async_loss_cnt", lock_loss_cnt, 8'd0);
    tick(2);
    #2 rst = 0;
    tick(30);
    chk("rerun_after_rst", 8'(lock_stable), 8'd1);
    for (int i = 0; i < 60; i++) begin
      lock = 1'($urandom_range(0, 1));
      ext_rst_req = $urandom_range(0, 9) == 0;
      tick(1);
      ext_rst_req = 0;
      tick($urandom_range(1, 50));
    end
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
